// File: rtl/mem_types_pkg.sv
// Shared types for the block memory server: block geometry, FSM states and
// requester port identifiers.
package mem_types_pkg;

    localparam int BLOCK_ADDR_SPACE_WIDTH = 29;
    localparam int WORD_ADDR_SPACE_WIDTH  = 30;
    localparam int MEM_WORD_WIDTH         = 32;
    localparam int MEM_WORDS_PER_BLOCK    = 1 << (WORD_ADDR_SPACE_WIDTH - BLOCK_ADDR_SPACE_WIDTH);

    typedef logic [MEM_WORDS_PER_BLOCK-1:0][MEM_WORD_WIDTH-1:0] mem_block_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_server_state_t;

    typedef enum logic {
        PORT_ICACHE,
        PORT_DCACHE
    } mem_port_t;

endpackage

// File: rtl/mem_req_arbiter.sv
// Two-port alternating-priority arbiter. A lone requester always wins; on
// contention the port named by prio wins and the caller flips prio.
module mem_req_arbiter
    import mem_types_pkg::*;
(
    input  logic      ic_req_i,
    input  logic      dc_req_i,
    input  mem_port_t prio_i,
    output logic      gnt_valid_o,
    output mem_port_t gnt_port_o,
    output logic      prio_flip_o
);

    // Pick the winner; flip is only requested when both ports contend.
    always_comb begin
        gnt_valid_o = ic_req_i | dc_req_i;
        prio_flip_o = ic_req_i & dc_req_i;
        if (ic_req_i && dc_req_i) begin
            gnt_port_o = prio_i;
        end else if (dc_req_i) begin
            gnt_port_o = PORT_DCACHE;
        end else begin
            gnt_port_o = PORT_ICACHE;
        end
    end

endmodule

// File: rtl/mem_block_server.sv
// Block-granular memory responder: accepts icache/dcache block requests,
// serialises each block into word accesses on the RAM port, and returns the
// block (or a writeback acknowledge) as a one-cycle response pulse.
module mem_block_server
    import mem_types_pkg::*;
#(
    parameter int BLOCK_ADDR_WIDTH = BLOCK_ADDR_SPACE_WIDTH,
    parameter int WORDS_PER_BLOCK  = MEM_WORDS_PER_BLOCK,
    parameter int WORD_WIDTH       = MEM_WORD_WIDTH
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic                                  icache_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0]           icache_req_block_addr,
    output logic                                  icache_req_ready,
    output logic                                  icache_resp_valid,
    output logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0] icache_resp_data,
    input  logic                                  dcache_req_valid,
    input  logic                                  dcache_req_write,
    input  logic [BLOCK_ADDR_WIDTH-1:0]           dcache_req_block_addr,
    input  logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0] dcache_req_data,
    output logic                                  dcache_req_ready,
    output logic                                  dcache_resp_valid,
    output logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0] dcache_resp_data,
    output logic                                  ram_REN,
    output logic                                  ram_WEN,
    output logic [31:0]                           ram_addr,
    output logic [WORD_WIDTH-1:0]                 ram_store,
    input  logic [WORD_WIDTH-1:0]                 ram_load,
    input  logic                                  ram_ready
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef logic [WORDS_PER_BLOCK-1:0][WORD_WIDTH-1:0] blk_t;

    mem_server_state_t           state_q, state_d;
    mem_port_t                   port_q, port_d;
    mem_port_t                   prio_q, prio_d;
    logic                        write_q, write_d;
    logic [BLOCK_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    blk_t                        buf_q, buf_d;
    logic                        ren_q, ren_d;
    logic                        wen_q, wen_d;
    logic [31:0]                 raddr_q, raddr_d;
    logic [WORD_WIDTH-1:0]       store_q, store_d;
    logic                        ic_resp_q, ic_resp_d;
    logic                        dc_resp_q, dc_resp_d;

    logic      gnt_valid;
    mem_port_t gnt_port;
    logic      prio_flip;
    logic      accept;
    logic      gnt_wb;
    blk_t      wb_blk;

    mem_req_arbiter u_arb (
        .ic_req_i    (icache_req_valid),
        .dc_req_i    (dcache_req_valid),
        .prio_i      (prio_q),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port),
        .prio_flip_o (prio_flip)
    );

    // Ready is only offered in IDLE and is forced low while reset is held.
    assign accept           = nRST && (state_q == IDLE) && gnt_valid;
    assign icache_req_ready = accept && (gnt_port == PORT_ICACHE);
    assign dcache_req_ready = accept && (gnt_port == PORT_DCACHE);
    assign gnt_wb           = (gnt_port == PORT_DCACHE) && dcache_req_write;
    assign wb_blk           = dcache_req_data;

    assign icache_resp_valid = ic_resp_q;
    assign dcache_resp_valid = dc_resp_q;
    assign icache_resp_data  = buf_q;
    assign dcache_resp_data  = buf_q;
    assign ram_REN           = ren_q;
    assign ram_WEN           = wen_q;
    assign ram_addr          = raddr_q;
    assign ram_store         = store_q;

    // Next-state logic for the FSM, datapath and registered outputs.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        prio_d    = prio_q;
        write_d   = write_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        raddr_d   = raddr_q;
        store_d   = store_q;
        ic_resp_d = 1'b0;
        dc_resp_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    port_d  = gnt_port;
                    write_d = gnt_wb;
                    addr_d  = (gnt_port == PORT_DCACHE) ? dcache_req_block_addr
                                                        : icache_req_block_addr;
                    idx_d   = '0;
                    if (gnt_wb) begin
                        buf_d = wb_blk;
                    end
                    if (prio_flip) begin
                        prio_d = (prio_q == PORT_DCACHE) ? PORT_ICACHE : PORT_DCACHE;
                    end
                    ren_d   = !gnt_wb;
                    wen_d   = gnt_wb;
                    raddr_d = 32'({addr_d, {IDX_W{1'b0}}, 2'b00});
                    store_d = gnt_wb ? wb_blk[0] : '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Without ram_ready every RAM output simply holds.
                if (ram_ready) begin
                    if (!write_q) begin
                        buf_d[idx_q] = ram_load;
                    end
                    if (idx_q == IDX_LAST) begin
                        ren_d     = 1'b0;
                        wen_d     = 1'b0;
                        ic_resp_d = (port_q == PORT_ICACHE);
                        dc_resp_d = (port_q == PORT_DCACHE);
                        state_d   = RESP;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        raddr_d = 32'({addr_q, idx_d, 2'b00});
                        if (write_q) begin
                            store_d = buf_q[idx_d];
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transfer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            port_q    <= PORT_ICACHE;
            prio_q    <= PORT_DCACHE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            idx_q     <= '0;
            buf_q     <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            raddr_q   <= '0;
            store_q   <= '0;
            ic_resp_q <= 1'b0;
            dc_resp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            prio_q    <= prio_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            raddr_q   <= raddr_d;
            store_q   <= store_d;
            ic_resp_q <= ic_resp_d;
            dc_resp_q <= dc_resp_d;
        end
    end

endmodule
